// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b, LSB first) with a routing select that
// steers each result to one of two valid/ready output channels.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic             out1_valid,
  input  logic             out1_ready
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             bit_d;
  logic             br_nxt;
  logic [WIDTH-1:0] a_shift;

  assign bit_d   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // Difference bits enter the minuend register from the MSB side as its bits
  // are consumed, so after WIDTH shifts it holds the full result.
  assign a_shift = {bit_d, a_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    sel_d    = sel_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_shift;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d   = a_shift;
          borrow_d = br_nxt;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (sel_q ? out1_ready : out0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      sel_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      sel_q    <= sel_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out0_valid = (state_q == DONE) && !sel_q;
  assign out1_valid = (state_q == DONE) &&  sel_q;
  assign out_diff   = diff_q;
  assign out_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed corner cases, backpressure, reset
// mid-operation and randomized back-to-back traffic against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       sel;
  logic [7:0] out_diff;
  logic       out_borrow;
  logic       out0_valid, out0_ready;
  logic       out1_valid, out1_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = -1;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_diff(out_diff), .out_borrow(out_borrow),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_ready(out1_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One full transaction: present pair, wait for accept, wait for the result,
  // apply `stall` cycles of backpressure on the selected channel, then handshake.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input int stall, input bit noisy);
    logic [7:0] exp_d;
    logic       exp_b;
    int n, lat, acc;
    exp_d = ta - tb_v;
    exp_b = (ta < tb_v);
    a = ta; b = tb_v; sel = ts; in_valid = 1'b1;
    out0_ready = ts;   // unselected channel's ready held high: must be ignored
    out1_ready = !ts;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_wait: in_ready=%b required=1 after %0d cycles", in_ready, n);
    end
    @(posedge clk); #1;
    acc = cyc;
    if (last_acc >= 0) begin
      checks++;
      if (acc - last_acc < 10) begin
        failures++;
        $display("FAIL init_interval: got=%0d required>=10", acc - last_acc);
      end
    end
    last_acc = acc;
    if (!noisy) in_valid = 1'b0;
    lat = 0;
    while (!(out0_valid || out1_valid) && lat < 20) begin
      if (noisy) begin a = 8'($urandom); b = 8'($urandom); sel = !ts; end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL latency: got=%0d required=8", lat);
    end
    checks++;
    if ({out0_valid, out1_valid, out_borrow, out_diff} !== {!ts, ts, exp_b, exp_d}) begin
      failures++;
      $display("FAIL result a=%h b=%h sel=%b: v0=%b v1=%b borrow=%b diff=%h required v0=%b v1=%b borrow=%b diff=%h",
               ta, tb_v, ts, out0_valid, out1_valid, out_borrow, out_diff, !ts, ts, exp_b, exp_d);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out0_valid, out1_valid, out_borrow, out_diff} !== {1'b0, !ts, ts, exp_b, exp_d}) begin
        failures++;
        $display("FAIL backpressure cycle %0d: rdy=%b v0=%b v1=%b borrow=%b diff=%h required rdy=0 v0=%b v1=%b borrow=%b diff=%h",
                 s, in_ready, out0_valid, out1_valid, out_borrow, out_diff, !ts, ts, exp_b, exp_d);
      end
    end
    if (ts) out1_ready = 1'b1; else out0_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out0_valid, out1_valid, out_diff} !== {1'b1, 1'b0, 1'b0, exp_d}) begin
      failures++;
      $display("FAIL post_handshake: rdy=%b v0=%b v1=%b diff=%h required rdy=1 v0=0 v1=0 diff=%h",
               in_ready, out0_valid, out1_valid, out_diff, exp_d);
    end
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #1;
    checks++;
    if ({in_ready, out0_valid, out1_valid, out_borrow, out_diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_values: rdy=%b v0=%b v1=%b borrow=%b diff=%h required 1 0 0 0 00",
               in_ready, out0_valid, out1_valid, out_borrow, out_diff);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out0_valid, out1_valid, out_diff} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL after_release: rdy=%b v0=%b v1=%b diff=%h required 1 0 0 00",
               in_ready, out0_valid, out1_valid, out_diff);
    end
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h05, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h5A, 8'h00, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(8'hC3, 8'h41, 1'b0, 5, 1'b0);
  endtask

  task automatic test_ignore_inputs();
    run_op(8'h9C, 8'h2D, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    a = 8'h77; b = 8'h11; sel = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out0_valid, out1_valid, out_borrow, out_diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL async_reset: rdy=%b v0=%b v1=%b borrow=%b diff=%h required 1 0 0 0 00",
               in_ready, out0_valid, out1_valid, out_borrow, out_diff);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    last_acc = -1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out0_valid, out1_valid} !== 3'b100) begin
      failures++;
      $display("FAIL discarded_op: rdy=%b v0=%b v1=%b required 1 0 0", in_ready, out0_valid, out1_valid);
    end
    run_op(8'h10, 8'h01, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    last_acc = -1;
    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
